// File: rtl/ex_mem_if.sv
// Handshake bundle between the ALU stage, the EX/MEM buffer and the memory stage.
// The slave modport is the buffer's view; the master modport drives the buffer.
interface ex_mem_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RD_W  = 3
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_result;
    logic             s_zero;
    logic             s_overflow;
    logic             s_neg;
    logic [RD_W-1:0]  s_rd;
    logic [3:0]       s_ctrl;
    logic [WIDTH-1:0] s_store_data;
    logic [2:0]       s_cond;
    logic             flush;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_result;
    logic [RD_W-1:0]  m_rd;
    logic [2:0]       m_ctrl;
    logic [WIDTH-1:0] m_store_data;
    logic             m_br_taken;
    logic [2:0]       flags;

    modport slave (
        input  s_valid, s_result, s_zero, s_overflow, s_neg, s_rd, s_ctrl, s_store_data, s_cond,
        input  flush, m_ready,
        output s_ready, m_valid, m_result, m_rd, m_ctrl, m_store_data, m_br_taken, flags
    );

    modport master (
        output s_valid, s_result, s_zero, s_overflow, s_neg, s_rd, s_ctrl, s_store_data, s_cond,
        output flush, m_ready,
        input  s_ready, m_valid, m_result, m_rd, m_ctrl, m_store_data, m_br_taken, flags
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: 2-entry elastic buffer with branch resolution at capture
// and the architectural {Z,V,N} status register.
module ex_mem_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RD_W  = 3,
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    ex_mem_if.slave  bus
);
    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RD_W-1:0]  rd;
        logic [2:0]       ctrl;
        logic [WIDTH-1:0] store_data;
        logic             br_taken;
    } entry_t;

    // head_q drives m_* directly so data hold when the buffer drains or flushes
    entry_t     head_q, head_d, skid_q, skid_d, in_entry;
    logic [1:0] count_q, count_d;
    logic [2:0] flags_q, flags_d;
    logic       s_ready_q, s_ready_d;
    logic       push, pop, m_valid, br_taken;

    always_comb begin
        unique case (bus.s_cond)
            3'd1:    br_taken = bus.s_zero;
            3'd2:    br_taken = !bus.s_zero;
            3'd3:    br_taken = bus.s_neg ^ bus.s_overflow;
            3'd4:    br_taken = !(bus.s_neg ^ bus.s_overflow);
            3'd5:    br_taken = bus.s_overflow;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        in_entry.result     = bus.s_result;
        in_entry.rd         = bus.s_rd;
        in_entry.ctrl       = bus.s_ctrl[3:1];
        in_entry.store_data = bus.s_store_data;
        in_entry.br_taken   = br_taken;
    end

    assign m_valid = (count_q != 2'd0);
    assign push    = bus.s_valid & s_ready_q;
    assign pop     = m_valid & bus.m_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        flags_d = flags_q;
        if (bus.flush) begin
            // a concurrent pop was already consumed downstream; a concurrent push is dropped
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = in_entry;
                    else                 skid_d = in_entry;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_d = skid_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // push is only possible below full, so count is 1 here
                    head_d = in_entry;
                end
                default: ;
            endcase
            if (push && bus.s_ctrl[0]) flags_d = {bus.s_zero, bus.s_overflow, bus.s_neg};
        end
        s_ready_d = ({30'd0, count_d} < DEPTH) && !bus.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            head_q    <= '0;
            skid_q    <= '0;
            flags_q   <= 3'b000;
            s_ready_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
            flags_q   <= flags_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign bus.s_ready      = s_ready_q;
    assign bus.m_valid      = m_valid;
    assign bus.m_result     = head_q.result;
    assign bus.m_rd         = head_q.rd;
    assign bus.m_ctrl       = head_q.ctrl;
    assign bus.m_store_data = head_q.store_data;
    assign bus.m_br_taken   = head_q.br_taken;
    assign bus.flags        = flags_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, pass-through, backpressure, branch/flags,
// streaming, flush and asynchronous reset, with hand-computed expectations.
module tb_ex_mem_stage;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ex_mem_if #(.WIDTH(16), .RD_W(3)) bus ();

    ex_mem_stage #(.WIDTH(16), .RD_W(3), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [2:0] rd,
                         input logic [3:0] ctrl, input logic z, input logic ov, input logic n,
                         input logic [2:0] cond);
        bus.s_valid      = v;
        bus.s_result     = res;
        bus.s_rd         = rd;
        bus.s_ctrl       = ctrl;
        bus.s_zero       = z;
        bus.s_overflow   = ov;
        bus.s_neg        = n;
        bus.s_cond       = cond;
        bus.s_store_data = res ^ 16'h5A5A;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.flush   = 1'b0;
        bus.m_ready = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);

        // Reset state
        #3;
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);
        check("rst_m_result", 32'(bus.m_result), 32'd0);
        check("rst_m_ctrl", 32'(bus.m_ctrl), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        check("rel_s_ready_low", 32'(bus.s_ready), 32'd0);
        step();
        check("rel_s_ready_high", 32'(bus.s_ready), 32'd1);

        // Pass-through
        bus.m_ready = 1'b1;
        drive(1'b1, 16'h000F, 3'd3, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b0, 16'h0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
        check("pt_m_valid", 32'(bus.m_valid), 32'd1);
        check("pt_m_result", 32'(bus.m_result), 32'h000F);
        check("pt_m_rd", 32'(bus.m_rd), 32'd3);
        check("pt_m_ctrl", 32'(bus.m_ctrl), 32'b100);
        check("pt_m_store", 32'(bus.m_store_data), 32'h5A55);
        step();
        check("pt_drained", 32'(bus.m_valid), 32'd0);
        check("pt_hold", 32'(bus.m_result), 32'h000F);

        // Backpressure
        bus.m_ready = 1'b0;
        drive(1'b1, 16'h0011, 3'd1, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 16'h0022, 3'd2, 4'b0100, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b0, 16'h0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
        check("bp_full_s_ready", 32'(bus.s_ready), 32'd0);
        check("bp_head", 32'(bus.m_result), 32'h0011);
        step();
        check("bp_stall_head", 32'(bus.m_result), 32'h0011);
        check("bp_stall_valid", 32'(bus.m_valid), 32'd1);
        bus.m_ready = 1'b1;
        step();
        check("bp_pop1_s_ready", 32'(bus.s_ready), 32'd1);
        check("bp_second", 32'(bus.m_result), 32'h0022);
        check("bp_second_ctrl", 32'(bus.m_ctrl), 32'b010);
        check("bp_second_valid", 32'(bus.m_valid), 32'd1);
        step();
        check("bp_empty", 32'(bus.m_valid), 32'd0);

        // Branch resolution and flags
        drive(1'b1, 16'h0000, 3'd4, 4'b0001, 1'b1, 1'b0, 1'b0, 3'd1);
        step();
        check("br_eq_taken", 32'(bus.m_br_taken), 32'd1);
        check("br_eq_flags", 32'(bus.flags), 32'b100);
        check("br_eq_ctrl", 32'(bus.m_ctrl), 32'b000);
        drive(1'b1, 16'h8000, 3'd5, 4'b1000, 1'b0, 1'b1, 1'b1, 3'd3);
        step();
        check("br_lt_not_taken", 32'(bus.m_br_taken), 32'd0);
        check("br_lt_flags_hold", 32'(bus.flags), 32'b100);
        drive(1'b1, 16'h8000, 3'd5, 4'b1000, 1'b0, 1'b1, 1'b1, 3'd4);
        step();
        check("br_ge_taken", 32'(bus.m_br_taken), 32'd1);
        drive(1'b1, 16'h0001, 3'd5, 4'b1000, 1'b1, 1'b0, 1'b0, 3'd2);
        step();
        check("br_ne_not_taken", 32'(bus.m_br_taken), 32'd0);
        drive(1'b1, 16'h0001, 3'd5, 4'b1000, 1'b0, 1'b1, 1'b0, 3'd5);
        step();
        check("br_ov_taken", 32'(bus.m_br_taken), 32'd1);
        drive(1'b1, 16'h0001, 3'd5, 4'b1000, 1'b1, 1'b1, 1'b1, 3'd6);
        step();
        check("br_never_6", 32'(bus.m_br_taken), 32'd0);
        drive(1'b0, 16'h0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
        step();

        // Streaming at one entry per cycle
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i), 3'(i), 4'b1000, 1'b0, 1'b0, 1'b0, 3'd0);
            step();
            check("st_valid", 32'(bus.m_valid), 32'd1);
            check("st_result", 32'(bus.m_result), 32'(i));
            check("st_s_ready", 32'(bus.s_ready), 32'd1);
        end
        drive(1'b0, 16'h0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        check("st_drained", 32'(bus.m_valid), 32'd0);

        // Flush with buffer full
        bus.m_ready = 1'b0;
        drive(1'b1, 16'h00A1, 3'd1, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 16'h00A2, 3'd2, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 16'h00A3, 3'd3, 4'b1001, 1'b0, 1'b0, 1'b1, 3'd0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
        check("fl_m_valid", 32'(bus.m_valid), 32'd0);
        check("fl_flags", 32'(bus.flags), 32'b100);
        check("fl_s_ready_low", 32'(bus.s_ready), 32'd0);
        check("fl_hold", 32'(bus.m_result), 32'h00A1);
        step();
        check("fl_s_ready_high", 32'(bus.s_ready), 32'd1);
        check("fl_still_empty", 32'(bus.m_valid), 32'd0);

        // Flush discards an accepted push and its flag update
        drive(1'b1, 16'h00B0, 3'd6, 4'b1001, 1'b0, 1'b1, 1'b1, 3'd0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
        check("flp_m_valid", 32'(bus.m_valid), 32'd0);
        check("flp_flags", 32'(bus.flags), 32'b100);
        check("flp_hold", 32'(bus.m_result), 32'h00A1);
        step();

        // Asynchronous reset mid-stream
        drive(1'b1, 16'h00C1, 3'd1, 4'b1001, 1'b0, 1'b0, 1'b1, 3'd0);
        step();
        drive(1'b1, 16'h00C2, 3'd2, 4'b1000, 1'b0, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b0, 16'h0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
        check("ar_pre_flags", 32'(bus.flags), 32'b001);
        check("ar_pre_full", 32'(bus.s_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_m_valid", 32'(bus.m_valid), 32'd0);
        check("ar_flags", 32'(bus.flags), 32'd0);
        check("ar_m_result", 32'(bus.m_result), 32'd0);
        check("ar_s_ready", 32'(bus.s_ready), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("ar_rel_s_ready", 32'(bus.s_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
